// File: rtl/sort_sequencer.sv
// Packet sorter sequencer: loads a sink packet into the shared RAM, hands it to
// the sort engine, then streams the sorted words out through a 2-entry FIFO.
module sort_sequencer #(
    parameter int DWIDTH  = 10,
    parameter int ADDR_SZ = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [DWIDTH-1:0]   snk_data_i,
    input  logic                snk_startofpacket_i,
    input  logic                snk_endofpacket_i,
    input  logic                snk_valid_i,
    output logic                snk_ready_o,
    output logic [DWIDTH-1:0]   src_data_o,
    output logic                src_startofpacket_o,
    output logic                src_endofpacket_o,
    output logic                src_valid_o,
    input  logic                src_ready_i,
    output logic                sort_start_o,
    output logic [ADDR_SZ:0]    sort_len_o,
    input  logic                sort_done_i,
    input  logic [ADDR_SZ-1:0]  srt_address_a_i,
    input  logic [ADDR_SZ-1:0]  srt_address_b_i,
    input  logic [DWIDTH-1:0]   srt_data_a_i,
    input  logic [DWIDTH-1:0]   srt_data_b_i,
    input  logic                srt_wren_a_i,
    input  logic                srt_wren_b_i,
    output logic [ADDR_SZ-1:0]  ram_address_a_o,
    output logic [ADDR_SZ-1:0]  ram_address_b_o,
    output logic [DWIDTH-1:0]   ram_data_a_o,
    output logic [DWIDTH-1:0]   ram_data_b_o,
    output logic                ram_wren_a_o,
    output logic                ram_wren_b_o,
    input  logic [DWIDTH-1:0]   ram_q_a_i,
    output logic                busy_o
);

    localparam int CW = ADDR_SZ + 1;
    localparam logic [CW-1:0] MAX_LEN = {1'b1, {ADDR_SZ{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_UNLOAD} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       len;
    logic [CW-1:0]       len_nxt;
    logic [CW-1:0]       len_m1;
    logic                sort_act_p1;
    logic                sort_first;
    logic                snk_acc;
    logic                load_wr;
    logic [ADDR_SZ-1:0]  load_addr;

    logic [CW-1:0]       rd_cnt;
    logic [CW-1:0]       out_cnt;
    logic                vld_p1;
    logic                rd_issue;
    logic [1:0]          occ_sum;
    logic [DWIDTH-1:0]   fifo_mem [2];
    logic                fifo_wr_ptr;
    logic                fifo_rd_ptr;
    logic [1:0]          fifo_occ;
    logic                fifo_pop;
    logic                last_pop;

    assign snk_acc    = snk_valid_i && snk_ready_o;
    assign len_m1     = len - CW'(1);
    assign sort_first = (state == S_SORT) && !sort_act_p1;

    // Load address/length decision for the current sink beat
    always_comb begin
        load_wr   = 1'b0;
        load_addr = '0;
        len_nxt   = len;
        if (snk_acc) begin
            if (snk_startofpacket_i) begin
                load_wr = 1'b1;
                len_nxt = CW'(1);
            end else if ((state == S_LOAD) && (len < MAX_LEN)) begin
                load_wr   = 1'b1;
                load_addr = len[ADDR_SZ-1:0];
                len_nxt   = len + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            len         <= '0;
            sort_act_p1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            sort_act_p1 <= (state == S_SORT);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (snk_acc && snk_startofpacket_i)
                    state_nxt = snk_endofpacket_i ? S_UNLOAD : S_LOAD;
            end
            S_LOAD: begin
                if (snk_acc && snk_endofpacket_i)
                    state_nxt = (len_nxt >= CW'(2)) ? S_SORT : S_UNLOAD;
            end
            S_SORT: begin
                if (sort_done_i && !sort_first)
                    state_nxt = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (last_pop)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // RAM port ownership follows the phase: sink writes, sort engine, unload reads
    always_comb begin
        snk_ready_o     = 1'b0;
        busy_o          = (state != S_IDLE);
        sort_start_o    = sort_first;
        ram_address_a_o = '0;
        ram_address_b_o = '0;
        ram_data_a_o    = '0;
        ram_data_b_o    = '0;
        ram_wren_a_o    = 1'b0;
        ram_wren_b_o    = 1'b0;
        case (state)
            S_IDLE, S_LOAD: begin
                snk_ready_o     = 1'b1;
                ram_address_a_o = load_addr;
                ram_data_a_o    = load_wr ? snk_data_i : '0;
                ram_wren_a_o    = load_wr;
            end
            S_SORT: begin
                ram_address_a_o = srt_address_a_i;
                ram_address_b_o = srt_address_b_i;
                ram_data_a_o    = srt_data_a_i;
                ram_data_b_o    = srt_data_b_i;
                ram_wren_a_o    = srt_wren_a_i;
                ram_wren_b_o    = srt_wren_b_i;
            end
            S_UNLOAD: begin
                ram_address_a_o = rd_cnt[ADDR_SZ-1:0];
            end
            default: ;
        endcase
    end

    assign sort_len_o = len;

    // Unload: a read is only issued if its word is guaranteed a FIFO slot
    assign occ_sum  = fifo_occ + {1'b0, vld_p1};
    assign rd_issue = (state == S_UNLOAD) && (rd_cnt < len) && (occ_sum < 2'd2);
    assign fifo_pop = src_valid_o && src_ready_i;
    assign last_pop = fifo_pop && (out_cnt == len_m1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_cnt      <= '0;
            out_cnt     <= '0;
            vld_p1      <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_occ    <= '0;
        end else if (state != S_UNLOAD) begin
            rd_cnt      <= '0;
            out_cnt     <= '0;
            vld_p1      <= 1'b0;
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_occ    <= '0;
        end else begin
            vld_p1 <= rd_issue;
            if (rd_issue)
                rd_cnt <= rd_cnt + CW'(1);
            if (vld_p1)
                fifo_wr_ptr <= ~fifo_wr_ptr;
            if (fifo_pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
                out_cnt     <= out_cnt + CW'(1);
            end
            fifo_occ <= fifo_occ + {1'b0, vld_p1} - {1'b0, fifo_pop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (vld_p1)
            fifo_mem[fifo_wr_ptr] <= ram_q_a_i;
    end

    assign src_valid_o         = (fifo_occ != 2'd0);
    assign src_data_o          = src_valid_o ? fifo_mem[fifo_rd_ptr] : '0;
    assign src_startofpacket_o = src_valid_o && (out_cnt == '0);
    assign src_endofpacket_o   = src_valid_o && (out_cnt == len_m1);

endmodule
